// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: buffers scan-code bytes in a small FIFO and
// serialises each one as an 11-bit frame (start, d0..d7, odd parity, stop).
//
// state  | meaning
// IDLE   | lines high, waiting for a queued byte while the host is not inhibiting
// BIT_HI | ps2_clk high; ps2_data presents the current frame bit
// BIT_LO | ps2_clk low; ps2_data held so the host samples a stable bit
// GAP    | both lines high for GAP_CYCLES before the next frame may start
module ps2_device_tx #(
  parameter int CLK_DIV    = 2000,
  parameter int GAP_CYCLES = 4000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_BIT = 4'd10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BIT_HI = 2'd1;
  localparam logic [1:0] S_BIT_LO = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [10:0]      shreg_q, shreg_d;
  logic             ps2_clk_q, ps2_clk_d;
  logic             ps2_data_q, ps2_data_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       pop_byte;

  // Full is taken from the registered count only, so a same-cycle pop never
  // opens room for a push.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    push     = in_valid && !full;
    pop      = (state_q == S_IDLE) && !empty && !inhibit;
    pop_byte = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    tx_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        cnt_d      = '0;
        if (pop) begin
          shreg_d    = {1'b1, ~^pop_byte, pop_byte, 1'b0};
          bit_d      = 4'd0;
          ps2_data_d = 1'b0;
          state_d    = S_BIT_HI;
        end
      end

      S_BIT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = S_BIT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BIT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            tx_done_d  = 1'b1;
            ps2_data_d = 1'b1;
            state_d    = S_GAP;
          end else begin
            // Next bit appears only as the clock returns high.
            bit_d      = bit_q + 1'b1;
            shreg_d    = {1'b1, shreg_q[10:1]};
            ps2_data_d = shreg_q[1];
            state_d    = S_BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      shreg_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready = (count_q != FULL_CNT);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: directed pushes feed a queue of hand-computed
// {parity, byte} frames; a receiver-style monitor decodes the lines and compares.
module tb_ps2_device_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       tx_done;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];

  ps2_device_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inhibit (inhibit),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // One-cycle push attempt; expected frame queued only if the DUT accepted it.
  task automatic push(input logic [7:0] b, input logic par, output bit acc);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    acc      = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (acc) exp_q.push_back({par, b});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, name, n, budget);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!tx_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, name, n, budget);
  endtask

  // Monitor: host-receiver model sampling ps2_data on ps2_clk falling edges.
  initial begin
    int         cyc = 0;
    int         last_chg = 0;
    int         start_cyc = 0;
    int         high_run = 0;
    logic [3:0] nb = 4'd0;
    logic [10:0] fr = '0;
    logic [8:0] e;
    bit         prev_clk = 1'b1;
    bit         prev_data = 1'b1;
    bit         prev_busy = 1'b0;
    bit         pending = 1'b0;
    bit         had_frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        nb        = 4'd0;
        pending   = 1'b0;
        had_frame = 1'b0;
        high_run  = 0;
        last_chg  = cyc;
      end else begin
        if (ps2_data !== prev_data) begin
          last_chg = cyc;
          chk(ps2_clk || prev_clk, "data_change_while_clk_low", int'(ps2_clk), 1);
        end
        if (busy && !prev_busy) begin
          start_cyc = cyc;
          nb        = 4'd0;
          chk(ps2_data === 1'b0, "start_bit_on_entry", int'(ps2_data), 0);
          if (had_frame) chk(high_run >= GAP, "gap_lines_high", high_run, GAP);
        end
        if (prev_clk && !ps2_clk) begin
          chk(cyc - last_chg >= CLK_DIV, "data_setup", cyc - last_chg, CLK_DIV);
          fr[nb] = ps2_data;
          nb     = nb + 4'd1;
          if (nb == 4'd11) begin
            nb      = 4'd0;
            pending = 1'b1;
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_frame", int'(fr), 0);
            end else begin
              e = exp_q.pop_front();
              chk(fr[0] == 1'b0, "start_bit", int'(fr[0]), 0);
              chk(fr[8:1] == e[7:0], "data_byte", int'(fr[8:1]), int'(e[7:0]));
              chk(fr[9] == e[8], "parity_bit", int'(fr[9]), int'(e[8]));
              chk(fr[10] == 1'b1, "stop_bit", int'(fr[10]), 1);
            end
          end
        end
        if (tx_done) begin
          chk(pending, "tx_done_without_frame", 0, 1);
          if (pending) chk(cyc - start_cyc == 22 * CLK_DIV, "tx_done_latency",
                           cyc - start_cyc, 22 * CLK_DIV);
          pending   = 1'b0;
          had_frame = 1'b1;
        end
        high_run = (ps2_clk && ps2_data) ? high_run + 1 : 0;
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
      prev_busy = busy;
    end
  end

  initial begin
    bit acc;
    bit quiet;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    inhibit  = 1'b0;
    repeat (3) @(negedge clk);
    chk(ps2_clk === 1'b1, "reset_ps2_clk", int'(ps2_clk), 1);
    chk(ps2_data === 1'b1, "reset_ps2_data", int'(ps2_data), 1);
    chk(busy === 1'b0, "reset_busy", int'(busy), 0);
    chk(tx_done === 1'b0, "reset_tx_done", int'(tx_done), 0);
    chk(in_ready === 1'b1, "reset_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0x1C: start bit two cycles after the push
    push(8'h1C, 1'b0, acc);
    chk(acc, "accept_1c", int'(acc), 1);
    chk(ps2_data === 1'b1, "no_start_at_t1", int'(ps2_data), 1);
    @(negedge clk);
    chk(ps2_data === 1'b0 && busy === 1'b1, "start_at_t2", int'(ps2_data), 0);
    wait_idle(400, "timeout_1c");

    // Loopback pair, back to back
    push(8'hF0, 1'b1, acc);
    push(8'h1C, 1'b0, acc);
    wait_idle(600, "timeout_f0_1c");

    // Parity corners
    push(8'h00, 1'b1, acc);
    push(8'h01, 1'b0, acc);
    push(8'hFF, 1'b1, acc);
    wait_idle(900, "timeout_parity");

    // Fill under inhibit
    inhibit = 1'b1;
    push(8'hA5, 1'b1, acc); chk(acc, "fill_accept_0", int'(acc), 1);
    push(8'h3C, 1'b1, acc); chk(acc, "fill_accept_1", int'(acc), 1);
    push(8'h12, 1'b1, acc); chk(acc, "fill_accept_2", int'(acc), 1);
    push(8'h07, 1'b0, acc); chk(acc, "fill_accept_3", int'(acc), 1);
    push(8'h55, 1'b1, acc); chk(!acc, "fifth_refused", int'(acc), 0);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(ps2_clk && ps2_data && !busy)) quiet = 1'b0;
    end
    chk(quiet, "inhibit_no_activity", int'(quiet), 1);
    chk(in_ready === 1'b0, "full_in_ready", int'(in_ready), 0);
    inhibit = 1'b0;
    @(negedge clk);
    chk(in_ready === 1'b1, "in_ready_after_pop", int'(in_ready), 1);
    wait_idle(2000, "timeout_fill");

    // Inhibit raised mid-frame with two bytes still queued
    push(8'h1C, 1'b0, acc);
    push(8'hF0, 1'b1, acc);
    push(8'h29, 1'b0, acc);
    repeat (20) @(negedge clk);
    inhibit = 1'b1;
    wait_done(200, "timeout_mid_inhibit");
    repeat (GAP + 20) @(negedge clk);
    chk(!busy && ps2_clk && ps2_data, "held_by_inhibit", int'(busy), 0);
    chk(exp_q.size() == 2, "queued_while_inhibit", exp_q.size(), 2);
    inhibit = 1'b0;
    @(negedge clk);
    chk(ps2_data === 1'b0 && busy === 1'b1, "resume_start", int'(ps2_data), 0);
    wait_idle(600, "timeout_resume");

    // Reset during bit 5 with a second byte queued
    push(8'h55, 1'b1, acc);
    push(8'h66, 1'b1, acc);
    repeat (41) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    chk(ps2_clk === 1'b1, "midreset_ps2_clk", int'(ps2_clk), 1);
    chk(ps2_data === 1'b1, "midreset_ps2_data", int'(ps2_data), 1);
    chk(busy === 1'b0, "midreset_busy", int'(busy), 0);
    chk(in_ready === 1'b1, "midreset_in_ready", int'(in_ready), 1);
    chk(tx_done === 1'b0, "midreset_tx_done", int'(tx_done), 0);
    repeat (100) @(negedge clk);
    chk(busy === 1'b0, "fifo_flushed_by_reset", int'(busy), 0);
    push(8'h29, 1'b0, acc);
    @(negedge clk);
    chk(ps2_data === 1'b0 && busy === 1'b1, "post_reset_start", int'(ps2_data), 0);
    wait_idle(400, "timeout_post_reset");

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
